// File: rtl/display_scan_controller.sv
// display_scan_controller
// Time-multiplexes one hex-to-7-segment decoder across DIGITS 4-bit sources.
// Each digit slot is SCAN_DIV cycles long. The first BLANK_CYCLES of a slot are
// dark to prevent ghosting, and the rest show the digit. All digit values and dots
// are snapshotted at the start of every frame, so a frame never mixes old and new
// values.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
// A suppressed digit keeps its timing, its digit enable and its decimal point.
module display_scan_controller #(
    parameter int DIGITS       = 3,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  input_clock1_1,
    input  logic                  input_reset_n_2,
    input  logic                  input_enable_3,
    input  logic [4*DIGITS-1:0]   input_digits_4,
    input  logic [DIGITS-1:0]     input_dots_5,
    output logic [6:0]            output_segments_6,
    output logic                  output_dp_7,
    output logic [DIGITS-1:0]     output_digit_en_8,
    output logic                  output_frame_done_9
);

    localparam int CNT_W       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SHOW_CYCLES = SCAN_DIV - BLANK_CYCLES;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_t;

    // A new slot begins dark unless blanking is disabled entirely
    localparam state_t SLOT_START = (BLANK_CYCLES > 0) ? BLANK : SHOW;

    state_t                state, state_next;
    logic [IDX_W-1:0]      idx, idx_next;
    logic [CNT_W-1:0]      slot_cnt, slot_cnt_next;
    logic [4*DIGITS-1:0]   snap_digits, snap_digits_next;
    logic [DIGITS-1:0]     snap_dots, snap_dots_next;
    logic                  capture;
    logic                  frame_end;

    logic [6:0]            segments_next;
    logic                  dp_next;
    logic [DIGITS-1:0]     digit_en_next;
    logic [3:0]            cur_digit;
    logic                  cur_dot;

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0]     suppress, suppress_next, capture_suppress;
    logic                  cur_suppress;
    logic                  upper_all_zero;
`endif

    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0:    seg = 7'b0111111;
            4'h1:    seg = 7'b0000110;
            4'h2:    seg = 7'b1011011;
            4'h3:    seg = 7'b1001111;
            4'h4:    seg = 7'b1100110;
            4'h5:    seg = 7'b1101101;
            4'h6:    seg = 7'b1111101;
            4'h7:    seg = 7'b0000111;
            4'h8:    seg = 7'b1111111;
            4'h9:    seg = 7'b1101111;
            4'hA:    seg = 7'b1110111;
            4'hB:    seg = 7'b1111100;
            4'hC:    seg = 7'b0111001;
            4'hD:    seg = 7'b1011110;
            4'hE:    seg = 7'b1111001;
            default: seg = 7'b1110001;
        endcase
        return seg;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // Walk from the top digit down: a digit is blanked while it and everything above it is zero with no dot
    always_comb begin
        capture_suppress = '0;
        upper_all_zero   = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_all_zero = upper_all_zero && (input_digits_4[4*i +: 4] == 4'h0) && !input_dots_5[i];
            capture_suppress[i] = upper_all_zero && (i != 0);
        end
    end
`endif

    // Next-state logic: slot timing, digit index stepping and frame snapshot capture
    always_comb begin
        state_next       = state;
        idx_next         = idx;
        slot_cnt_next    = slot_cnt + 1'b1;
        snap_digits_next = snap_digits;
        snap_dots_next   = snap_dots;
        capture          = 1'b0;
        frame_end        = 1'b0;

        case (state)
            IDLE: begin
                slot_cnt_next = '0;
                idx_next      = '0;
                if (input_enable_3) begin
                    capture    = 1'b1;
                    state_next = SLOT_START;
                end
            end
            BLANK: begin
                if (!input_enable_3) begin
                    state_next    = IDLE;
                    idx_next      = '0;
                    slot_cnt_next = '0;
                end else if (slot_cnt == BLANK_LAST) begin
                    state_next    = SHOW;
                    slot_cnt_next = '0;
                end
            end
            SHOW: begin
                if (!input_enable_3) begin
                    state_next    = IDLE;
                    idx_next      = '0;
                    slot_cnt_next = '0;
                end else if (slot_cnt == SHOW_LAST) begin
                    slot_cnt_next = '0;
                    state_next    = SLOT_START;
                    if (idx == IDX_LAST) begin
                        idx_next  = '0;
                        frame_end = 1'b1;
                        capture   = 1'b1;
                    end else begin
                        idx_next  = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_next    = IDLE;
                idx_next      = '0;
                slot_cnt_next = '0;
            end
        endcase

        if (capture) begin
            snap_digits_next = input_digits_4;
            snap_dots_next   = input_dots_5;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // The suppress mask is refreshed together with the snapshot it describes
    always_comb begin
        suppress_next = capture ? capture_suppress : suppress;
    end
`endif

    // Output decode from the upcoming state so outputs switch on the same edge as the state
    always_comb begin
        segments_next = '0;
        dp_next       = 1'b0;
        digit_en_next = '0;
        cur_digit     = '0;
        cur_dot       = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        cur_suppress  = 1'b0;
`endif
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_next == IDX_W'(i)) begin
                cur_digit = snap_digits_next[4*i +: 4];
                cur_dot   = snap_dots_next[i];
`ifdef LEADING_ZERO_BLANK_EN
                cur_suppress = suppress_next[i];
`endif
            end
        end
        if (state_next == SHOW) begin
            digit_en_next = DIGITS'(1) << idx_next;
            dp_next       = cur_dot;
`ifdef LEADING_ZERO_BLANK_EN
            segments_next = cur_suppress ? 7'b0000000 : hex_to_seg(cur_digit);
`else
            segments_next = hex_to_seg(cur_digit);
`endif
        end
    end

    // State, snapshot and registered outputs; reset forces everything dark immediately
    always_ff @(posedge input_clock1_1 or negedge input_reset_n_2) begin
        if (!input_reset_n_2) begin
            state               <= IDLE;
            idx                 <= '0;
            slot_cnt            <= '0;
            snap_digits         <= '0;
            snap_dots           <= '0;
            output_segments_6   <= '0;
            output_dp_7         <= 1'b0;
            output_digit_en_8   <= '0;
            output_frame_done_9 <= 1'b0;
        end else begin
            state               <= state_next;
            idx                 <= idx_next;
            slot_cnt            <= slot_cnt_next;
            snap_digits         <= snap_digits_next;
            snap_dots           <= snap_dots_next;
            output_segments_6   <= segments_next;
            output_dp_7         <= dp_next;
            output_digit_en_8   <= digit_en_next;
            output_frame_done_9 <= frame_end;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Suppress mask register, cleared alongside the snapshot
    always_ff @(posedge input_clock1_1 or negedge input_reset_n_2) begin
        if (!input_reset_n_2) begin
            suppress <= '0;
        end else begin
            suppress <= suppress_next;
        end
    end
`endif

endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller
// Scoreboard bench: a frame-timing reference model pushes the expected outputs for
// every clock edge, and a monitor pops and compares them on the falling edge.
// The reference model honours LEADING_ZERO_BLANK_EN when it is defined.
module tb_display_scan_controller;

    localparam int DIGITS       = 3;
    localparam int SCAN_DIV     = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int FRAME        = DIGITS * SCAN_DIV;

    logic                clk;
    logic                rst_n;
    logic                en;
    logic [4*DIGITS-1:0] digits;
    logic [DIGITS-1:0]   dots;
    logic [6:0]          dut_seg;
    logic                dut_dp;
    logic [DIGITS-1:0]   dut_en;
    logic                dut_fd;

    typedef struct {
        logic [6:0]        seg;
        logic              dp;
        logic [DIGITS-1:0] en;
        logic              fd;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int reset_events = 0;

    string seg_letters [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                                "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    display_scan_controller #(
        .DIGITS(DIGITS),
        .SCAN_DIV(SCAN_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .input_clock1_1(clk),
        .input_reset_n_2(rst_n),
        .input_enable_3(en),
        .input_digits_4(digits),
        .input_dots_5(dots),
        .output_segments_6(dut_seg),
        .output_dp_7(dut_dp),
        .output_digit_en_8(dut_en),
        .output_frame_done_9(dut_fd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build segment patterns from the letter lists of the hex table
    function automatic logic [6:0] ref_segments(input int value);
        logic [6:0] seg;
        string      letters;
        seg     = '0;
        letters = seg_letters[value];
        for (int c = 0; c < letters.len(); c++) begin
            seg[int'(letters[c]) - 97] = 1'b1;
        end
        return seg;
    endfunction

    // Reference model state
    bit active = 0;
    int k = 0;
    int seen_resets = 0;
    int snap_d [DIGITS];
    bit snap_p [DIGITS];
    bit supp   [DIGITS];

    task automatic capture_frame();
        bit all_zero;
        for (int i = 0; i < DIGITS; i++) begin
            snap_d[i] = int'(digits[4*i +: 4]);
            snap_p[i] = dots[i];
            supp[i]   = 0;
        end
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 1; i < DIGITS; i++) begin
            all_zero = 1;
            for (int j = i; j < DIGITS; j++) begin
                if (snap_d[j] != 0 || snap_p[j]) all_zero = 0;
            end
            supp[i] = all_zero;
        end
`else
        all_zero = 0;
`endif
    endtask

    // Count reset assertions so the model notices pulses that fall between edges
    always @(negedge rst_n) reset_events++;

    // Reference model: time since frame capture determines slot, digit and blanking
    always @(posedge clk) begin
        exp_t e;
        int   p;
        int   di;
        int   s;
        e.seg = '0;
        e.dp  = 1'b0;
        e.en  = '0;
        e.fd  = 1'b0;
        if (!rst_n) begin
            active      = 0;
            seen_resets = reset_events;
        end else begin
            if (seen_resets != reset_events) begin
                active      = 0;
                seen_resets = reset_events;
            end
            if (!active) begin
                if (en) begin
                    active = 1;
                    k      = 0;
                    capture_frame();
                end
            end else if (!en) begin
                active = 0;
            end else begin
                k++;
                if (k % FRAME == 0) capture_frame();
            end
            if (active) begin
                p    = k % FRAME;
                di   = p / SCAN_DIV;
                s    = p % SCAN_DIV;
                e.fd = (k > 0) && (p == 0);
                if (s >= BLANK_CYCLES) begin
                    e.en  = DIGITS'(1) << di;
                    e.seg = supp[di] ? 7'b0 : ref_segments(snap_d[di]);
                    e.dp  = snap_p[di];
                end
            end
        end
        exp_q.push_back(e);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h, required %h", name, $time, actual, required);
        end
    endtask

    // Monitor: compare queued expectations on the falling edge; check async reset directly
    always @(negedge clk or negedge rst_n) begin
        exp_t e;
        if (!rst_n && exp_q.size() == 0) begin
            #1;
            checkOutput("async_reset_segments", 32'(dut_seg), 32'd0);
            checkOutput("async_reset_dp", 32'(dut_dp), 32'd0);
            checkOutput("async_reset_digit_en", 32'(dut_en), 32'd0);
            checkOutput("async_reset_frame_done", 32'(dut_fd), 32'd0);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("segments", 32'(dut_seg), 32'(e.seg));
            checkOutput("dp", 32'(dut_dp), 32'(e.dp));
            checkOutput("digit_en", 32'(dut_en), 32'(e.en));
            checkOutput("frame_done", 32'(dut_fd), 32'(e.fd));
        end
    end

    task automatic applyStimulus(input logic enable, input logic [4*DIGITS-1:0] value, input logic [DIGITS-1:0] dot_req);
        en     = enable;
        digits = value;
        dots   = dot_req;
    endtask

    // Watchdog so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    // Stimulus: directed scenarios first, then a long randomized run
    initial begin
        logic [4*DIGITS-1:0] rnd_digits;
        rst_n = 1'b1;
        applyStimulus(1'b0, '0, '0);
        #1;
        rst_n = 1'b0;
        applyStimulus(1'b1, 12'h321, 3'b100);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset released, scanning 0x321");

        repeat (12) @(negedge clk);
        applyStimulus(1'b1, 12'hFFF, 3'b100);
        repeat (40) @(negedge clk);

        $display("[TB] enable drop and re-enable");
        applyStimulus(1'b0, 12'hFFF, 3'b100);
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 12'h0A7, 3'b001);
        repeat (12) @(negedge clk);
        applyStimulus(1'b0, 12'h0A7, 3'b001);
        repeat (2) @(negedge clk);
        applyStimulus(1'b1, 12'h5B0, 3'b010);
        repeat (12) @(negedge clk);

        $display("[TB] async reset pulse during blanking");
        applyStimulus(1'b0, 12'h5B0, 3'b010);
        repeat (2) @(negedge clk);
        applyStimulus(1'b1, 12'h5B0, 3'b010);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        repeat (30) @(negedge clk);

        $display("[TB] leading zero patterns");
        applyStimulus(1'b1, 12'h005, 3'b000);
        repeat (2 * FRAME + 3) @(negedge clk);
        applyStimulus(1'b1, 12'h005, 3'b010);
        repeat (2 * FRAME + 3) @(negedge clk);
        applyStimulus(1'b1, 12'h000, 3'b000);
        repeat (2 * FRAME) @(negedge clk);

        $display("[TB] reset held mid-frame");
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);

        $display("[TB] randomized run");
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 49) == 0) en = ~en;
            if ($urandom_range(0, 9) == 0) begin
                rnd_digits = 12'($urandom);
                case ($urandom_range(0, 3))
                    0: rnd_digits = rnd_digits & 12'h00F;
                    1: rnd_digits = rnd_digits & 12'h0FF;
                    default: rnd_digits = rnd_digits;
                endcase
                digits = rnd_digits;
                dots   = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
            end
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
